// File: rtl/temp_ctrl_pkg.sv
// Shared constants for the temperature alarm controller: state encodings, alarm causes and
// event counter sizing.
package temp_ctrl_pkg;

  localparam logic [2:0] NORMAL    = 3'd0;
  localparam logic [2:0] LOW_PEND  = 3'd1;
  localparam logic [2:0] LOW_ACT   = 3'd2;
  localparam logic [2:0] HIGH_PEND = 3'd3;
  localparam logic [2:0] HIGH_ACT  = 3'd4;
  localparam logic [2:0] FAULT     = 3'd5;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_LOW   = 2'b01;
  localparam logic [1:0] CAUSE_HIGH  = 2'b10;
  localparam logic [1:0] CAUSE_FAULT = 2'b11;

  localparam int unsigned EVENT_W   = 8;
  localparam int unsigned EVENT_MAX = 255;

endpackage

// File: rtl/temp_alarm_controller_if.sv
// Detector/panel-facing signal bundle of the temperature alarm controller.
interface temp_alarm_controller_if;
  import temp_ctrl_pkg::*;

  logic               sampleValid;
  logic               lowTempAbnormality;
  logic               highTempAbnormality;
  logic               alarmAck;
  logic               heaterOn;
  logic               coolerOn;
  logic               alarmLatched;
  logic [1:0]         alarmCause;
  logic [EVENT_W-1:0] eventCount;
  logic [2:0]         ctrlState;

  modport master (
    output sampleValid, lowTempAbnormality, highTempAbnormality, alarmAck,
    input  heaterOn, coolerOn, alarmLatched, alarmCause, eventCount, ctrlState
  );

  modport slave (
    input  sampleValid, lowTempAbnormality, highTempAbnormality, alarmAck,
    output heaterOn, coolerOn, alarmLatched, alarmCause, eventCount, ctrlState
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at MAX instead of wrapping; clear is synchronous and wins over inc.
module sat_counter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != WIDTH'(MAX))) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/temp_alarm_controller.sv
// Persistence filter over the detector's low/high flags, driving heater/cooler, a sticky
// operator alarm and a saturating count of confirmed events.
module temp_alarm_controller
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned PERSIST       = 4,
  parameter int unsigned CLEAR_PERSIST = 4,
  parameter int unsigned CNT_W         = 3
) (
  input logic                    clk,
  input logic                    rst,
  temp_alarm_controller_if.slave bus
);

  localparam logic [CNT_W-1:0] PersistCnt = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] ClearCnt   = CNT_W'(CLEAR_PERSIST);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cntInc;
  logic             alarmLatched_q, alarmLatched_d;
  logic [1:0]       alarmCause_q, alarmCause_d;
  logic             eventInc;
  logic             lowS, highS, cleanS, bothS;
  logic             enterLow, enterHigh, confirmLow, confirmHigh;

  assign lowS   = bus.sampleValid & bus.lowTempAbnormality & ~bus.highTempAbnormality;
  assign highS  = bus.sampleValid & ~bus.lowTempAbnormality & bus.highTempAbnormality;
  assign cleanS = bus.sampleValid & ~bus.lowTempAbnormality & ~bus.highTempAbnormality;
  assign bothS  = bus.sampleValid & bus.lowTempAbnormality & bus.highTempAbnormality;
  assign cntInc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alarmLatched_d = alarmLatched_q;
    alarmCause_d   = alarmCause_q;
    eventInc       = 1'b0;
    enterLow       = 1'b0;
    enterHigh      = 1'b0;
    confirmLow     = 1'b0;
    confirmHigh    = 1'b0;

    if (state_q > FAULT) begin
      state_d = NORMAL;
      cnt_d   = '0;
    end else if (bothS) begin
      // A both-flags sample outranks ack; re-entering FAULT is not a new event.
      state_d        = FAULT;
      cnt_d          = '0;
      alarmLatched_d = 1'b1;
      alarmCause_d   = CAUSE_FAULT;
      eventInc       = (state_q != FAULT);
    end else begin
      case (state_q)
        NORMAL: begin
          if (bus.alarmAck) alarmLatched_d = 1'b0;
          enterLow  = lowS;
          enterHigh = highS;
        end
        LOW_PEND: begin
          if (lowS) begin
            if (cntInc == PersistCnt) confirmLow = 1'b1;
            else                      cnt_d      = cntInc;
          end
          enterHigh = highS;
          if (cleanS) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end
        end
        HIGH_PEND: begin
          if (highS) begin
            if (cntInc == PersistCnt) confirmHigh = 1'b1;
            else                      cnt_d       = cntInc;
          end
          enterLow = lowS;
          if (cleanS) begin
            state_d = NORMAL;
            cnt_d   = '0;
          end
        end
        LOW_ACT: begin
          if (cleanS) begin
            if (cntInc == ClearCnt) begin
              state_d = NORMAL;
              cnt_d   = '0;
            end else begin
              cnt_d = cntInc;
            end
          end
          if (lowS) cnt_d = '0;
          enterHigh = highS;
        end
        HIGH_ACT: begin
          if (cleanS) begin
            if (cntInc == ClearCnt) begin
              state_d = NORMAL;
              cnt_d   = '0;
            end else begin
              cnt_d = cntInc;
            end
          end
          if (highS) cnt_d = '0;
          enterLow = lowS;
        end
        FAULT: begin
          if (bus.alarmAck) begin
            state_d        = NORMAL;
            cnt_d          = '0;
            alarmLatched_d = 1'b0;
          end
        end
        default: ;
      endcase

      // A single abnormal sample confirms immediately when PERSIST is 1.
      if (enterLow) begin
        if (PERSIST == 1) begin
          confirmLow = 1'b1;
        end else begin
          state_d = LOW_PEND;
          cnt_d   = CNT_W'(1);
        end
      end
      if (enterHigh) begin
        if (PERSIST == 1) begin
          confirmHigh = 1'b1;
        end else begin
          state_d = HIGH_PEND;
          cnt_d   = CNT_W'(1);
        end
      end

      if (confirmLow) begin
        state_d        = LOW_ACT;
        cnt_d          = '0;
        alarmLatched_d = 1'b1;
        alarmCause_d   = CAUSE_LOW;
        eventInc       = 1'b1;
      end
      if (confirmHigh) begin
        state_d        = HIGH_ACT;
        cnt_d          = '0;
        alarmLatched_d = 1'b1;
        alarmCause_d   = CAUSE_HIGH;
        eventInc       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= NORMAL;
      cnt_q          <= '0;
      alarmLatched_q <= 1'b0;
      alarmCause_q   <= CAUSE_NONE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alarmLatched_q <= alarmLatched_d;
      alarmCause_q   <= alarmCause_d;
    end
  end

  sat_counter #(
    .WIDTH (EVENT_W),
    .MAX   (EVENT_MAX)
  ) uEventCnt (
    .clk   (clk),
    .clear (rst),
    .inc   (eventInc),
    .count (bus.eventCount)
  );

  assign bus.heaterOn     = (state_q == LOW_ACT);
  assign bus.coolerOn     = (state_q == HIGH_ACT);
  assign bus.alarmLatched = alarmLatched_q;
  assign bus.alarmCause   = alarmCause_q;
  assign bus.ctrlState    = state_q;

endmodule

// File: tb/tb_temp_alarm_controller.sv
// Scoreboard bench: each stimulus cycle queues its expected post-edge outputs; a monitor
// pops one entry after every rising edge and compares.
module tb_temp_alarm_controller;

  typedef struct packed {
    logic       heater;
    logic       cooler;
    logic       latched;
    logic [1:0] cause;
    logic [7:0] ev;
    logic [2:0] st;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  obs_t  expQ[$];
  string nameQ[$];

  temp_alarm_controller_if bus ();

  temp_alarm_controller #(
    .PERSIST       (4),
    .CLEAR_PERSIST (4),
    .CNT_W         (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(input int h, input int c, input int l, input int cause,
                              input int ev, input int st);
    obs_t o;
    o.heater  = 1'(h);
    o.cooler  = 1'(c);
    o.latched = 1'(l);
    o.cause   = 2'(cause);
    o.ev      = 8'(ev);
    o.st      = 3'(st);
    return o;
  endfunction

  task automatic step(input int r, input int v, input int lo, input int hi, input int ack,
                      input obs_t e, input string nm);
    @(negedge clk);
    rst                     = 1'(r);
    bus.sampleValid         = 1'(v);
    bus.lowTempAbnormality  = 1'(lo);
    bus.highTempAbnormality = 1'(hi);
    bus.alarmAck            = 1'(ack);
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  // Monitor: outputs are registered, so each edge presents one new response.
  always @(posedge clk) begin
    obs_t  got, want;
    string nm;
    #1;
    if (expQ.size() > 0) begin
      want = expQ.pop_front();
      nm   = nameQ.pop_front();
      got  = {bus.heaterOn, bus.coolerOn, bus.alarmLatched, bus.alarmCause,
              bus.eventCount, bus.ctrlState};
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL %s got h=%b c=%b l=%b cause=%b ev=%0d st=%0d want h=%b c=%b l=%b cause=%b ev=%0d st=%0d",
                 nm, got.heater, got.cooler, got.latched, got.cause, got.ev, got.st,
                 want.heater, want.cooler, want.latched, want.cause, want.ev, want.st);
      end
    end
  end

  initial begin
    int ev;
    bus.sampleValid         = 1'b0;
    bus.lowTempAbnormality  = 1'b0;
    bus.highTempAbnormality = 1'b0;
    bus.alarmAck            = 1'b0;

    // Reset with all flags high
    step(1, 1, 1, 1, 1, mk(0, 0, 0, 0, 0, 0), "reset0");
    step(1, 1, 1, 1, 1, mk(0, 0, 0, 0, 0, 0), "reset1");

    // Confirm low after four samples
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 1), "low1");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 1), "low2");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 0, 0, 1), "low3");
    step(0, 1, 1, 0, 0, mk(1, 0, 1, 1, 1, 2), "low4Act");
    step(0, 0, 0, 0, 1, mk(1, 0, 1, 1, 1, 2), "ackIgnoredInAct");
    step(0, 1, 0, 0, 0, mk(1, 0, 1, 1, 1, 2), "clean1");
    step(0, 1, 0, 0, 0, mk(1, 0, 1, 1, 1, 2), "clean2");
    step(0, 1, 0, 0, 0, mk(1, 0, 1, 1, 1, 2), "clean3");
    step(0, 1, 0, 0, 0, mk(0, 0, 1, 1, 1, 0), "clean4Normal");
    step(0, 0, 0, 0, 1, mk(0, 0, 0, 1, 1, 0), "ackNormal");

    // Broken run restarts; invalid gaps hold the count
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "brk1");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "brk2");
    step(0, 1, 0, 0, 0, mk(0, 0, 0, 1, 1, 0), "brkClean");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "run1");
    step(0, 0, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "gap1");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "run2");
    step(0, 0, 1, 1, 0, mk(0, 0, 0, 1, 1, 1), "gap2");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 1, 1, 1), "run3Pend");
    step(0, 1, 1, 0, 0, mk(1, 0, 1, 1, 2, 2), "run4Act");

    // LOW_ACT -> HIGH_PEND -> HIGH_ACT -> LOW_PEND
    step(0, 1, 0, 1, 0, mk(0, 0, 1, 1, 2, 3), "hiFromLowAct");
    step(0, 1, 0, 1, 0, mk(0, 0, 1, 1, 2, 3), "hi2");
    step(0, 1, 0, 1, 0, mk(0, 0, 1, 1, 2, 3), "hi3");
    step(0, 1, 0, 1, 0, mk(0, 1, 1, 2, 3, 4), "highAct");
    step(0, 1, 1, 0, 0, mk(0, 0, 1, 2, 3, 1), "lowFromHighAct");
    step(0, 1, 1, 0, 0, mk(0, 0, 1, 2, 3, 1), "lowB2");
    step(0, 1, 1, 0, 0, mk(0, 0, 1, 2, 3, 1), "lowB3");
    step(0, 1, 1, 0, 0, mk(1, 0, 1, 1, 4, 2), "lowB4Act");

    // Sensor fault
    step(0, 1, 1, 1, 0, mk(0, 0, 1, 3, 5, 5), "faultEnter");
    step(0, 1, 1, 1, 1, mk(0, 0, 1, 3, 5, 5), "faultBothAck");
    step(0, 1, 1, 0, 0, mk(0, 0, 1, 3, 5, 5), "faultIgnoresLow");
    step(0, 0, 0, 0, 1, mk(0, 0, 0, 3, 5, 0), "faultExit");

    // Drive eventCount into saturation via fault/ack pairs
    ev = 5;
    for (int i = 0; i < 260; i++) begin
      ev = (ev < 255) ? ev + 1 : 255;
      step(0, 1, 1, 1, 0, mk(0, 0, 1, 3, ev, 5), "satFault");
      step(0, 0, 0, 0, 1, mk(0, 0, 0, 3, ev, 0), "satAck");
    end
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 3, 255, 1), "satLow1");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 3, 255, 1), "satLow2");
    step(0, 1, 1, 0, 0, mk(0, 0, 0, 3, 255, 1), "satLow3");
    step(0, 1, 1, 0, 0, mk(1, 0, 1, 1, 255, 2), "satLowAct");

    // Reset mid HIGH_PEND, then a full four-sample run is needed again
    step(0, 1, 0, 1, 0, mk(0, 0, 1, 1, 255, 3), "pendBeforeRst");
    step(0, 1, 0, 1, 0, mk(0, 0, 1, 1, 255, 3), "pend2BeforeRst");
    step(1, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 0), "rstInPend");
    step(0, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 3), "postRst1");
    step(0, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 3), "postRst2");
    step(0, 1, 0, 1, 0, mk(0, 0, 0, 0, 0, 3), "postRst3");
    step(0, 1, 0, 1, 0, mk(0, 1, 1, 2, 1, 4), "postRst4Act");

    @(negedge clk);
    bus.sampleValid = 1'b0;
    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    if (expQ.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want 0", expQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
